// File: rtl/fir_pkg.sv
// Shared state encoding, width defaults and elaboration helpers for the
// single-multiplier FIR filter.
package fir_pkg;

  localparam int DEF_DATA_W    = 24;
  localparam int DEF_COEF_W    = 24;
  localparam int DEF_TAPS      = 128;
  localparam int DEF_OUT_SHIFT = 24;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_MAC,
    ST_HOLD
  } fir_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fir_mac_core.sv
// Multiply / accumulate / round / saturate datapath: product register,
// accumulator, rounding-shift register, then a saturated result register.
module fir_mac_core import fir_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int ADDR_W    = clog2(DEF_TAPS),
  parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     tap_valid,
  input  logic                     tap_last,
  input  logic signed [DATA_W-1:0] tap_x,
  input  logic signed [COEF_W-1:0] tap_h,
  output logic                     done,
  output logic signed [DATA_W-1:0] result
);

  localparam int PROD_W   = DATA_W + COEF_W;
  localparam int ACC_W    = PROD_W + ADDR_W;
  localparam int BIAS_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [ACC_W-1:0] RND_BIAS =
    (OUT_SHIFT > 0) ? (ACC_W'(1) <<< BIAS_POS) : '0;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [PROD_W-1:0] prod_q;
  logic                     prod_valid;
  logic                     prod_last;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     acc_done;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  rnd_q;
  logic                     rnd_valid;
  logic signed [DATA_W-1:0] sat_val;

  assign rnd_sum = acc_q + RND_BIAS;
  assign done    = rnd_valid;

  always_comb begin
    sat_val = rnd_q[DATA_W-1:0];
    if (rnd_q > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end else if (rnd_q < SAT_MIN) begin
      sat_val = SAT_MIN[DATA_W-1:0];
    end
  end

  // Accumulator has log2(TAPS) guard bits, so a full-scale sum cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
      acc_q      <= '0;
      acc_done   <= 1'b0;
      rnd_q      <= '0;
      rnd_valid  <= 1'b0;
      result     <= '0;
    end else begin
      prod_valid <= tap_valid;
      prod_last  <= tap_valid && tap_last;
      prod_q     <= PROD_W'(tap_x) * PROD_W'(tap_h);
      acc_done   <= prod_valid && prod_last;
      if (start) begin
        acc_q <= '0;
      end else if (prod_valid) begin
        acc_q <= acc_q + ACC_W'(prod_q);
      end
      rnd_valid <= acc_done;
      if (acc_done) begin
        rnd_q <= rnd_sum >>> OUT_SHIFT;
      end
      if (rnd_valid) begin
        result <= sat_val;
      end
    end
  end

endmodule

// File: rtl/fir_mac_par.sv
// Time-multiplexed FIR filter: one sample in, TAPS sequential MACs through a
// single multiplier, one saturated sample out with valid/ready handshake.
module fir_mac_par import fir_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int COEF_W    = DEF_COEF_W,
  parameter int TAPS      = DEF_TAPS,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [DATA_W-1:0]  out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      coef_we,
  input  logic [clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      busy
);

  localparam int ADDR_W = clog2(TAPS);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

  fir_state_e state;
  fir_state_e state_nxt;

  logic [ADDR_W-1:0]  cnt;
  logic [ADDR_W-1:0]  w_ptr;
  logic [ADDR_W-1:0]  rd_addr;
  logic               issue_done;
  logic               issuing;
  logic               accept;
  logic               rd_valid;
  logic               rd_last;
  logic               coef_wr;
  logic               delay_we;
  logic [ADDR_W-1:0]  delay_waddr;
  logic signed [DATA_W-1:0] delay_wdata;
  logic signed [DATA_W-1:0] delay_q;
  logic signed [COEF_W-1:0] coef_q;
  logic               core_done;

  logic signed [DATA_W-1:0] delay_mem [TAPS];
  logic signed [COEF_W-1:0] coef_mem  [TAPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      ST_CLEAR: if (cnt == LAST_TAP) state_nxt = ST_IDLE;
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ST_MAC;
      end
      ST_MAC: if (core_done) state_nxt = ST_HOLD;
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign issuing     = (state == ST_MAC) && !issue_done;
  assign coef_wr     = coef_we && (state == ST_IDLE);
  assign delay_we    = (state == ST_CLEAR) || accept;
  assign delay_waddr = (state == ST_CLEAR) ? cnt : w_ptr;
  assign delay_wdata = (state == ST_CLEAR) ? '0 : in_data;
  // w_ptr already points past the newest sample while MAC runs.
  assign rd_addr     = w_ptr - ADDR_W'(1) - cnt;

  // cnt walks the delay line in CLEAR and the tap index in MAC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      w_ptr      <= '0;
      issue_done <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      rd_valid <= issuing;
      rd_last  <= issuing && (cnt == LAST_TAP);
      if (accept) begin
        w_ptr      <= w_ptr + ADDR_W'(1);
        cnt        <= '0;
        issue_done <= 1'b0;
      end else if ((state == ST_CLEAR) || issuing) begin
        cnt <= cnt + ADDR_W'(1);
        if (issuing && (cnt == LAST_TAP)) issue_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (delay_we) delay_mem[delay_waddr] <= delay_wdata;
    if (coef_wr) coef_mem[coef_addr] <= coef_data;
    delay_q <= delay_mem[rd_addr];
    coef_q  <= coef_mem[cnt];
  end

  fir_mac_core #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .ADDR_W    (ADDR_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .tap_valid (rd_valid),
    .tap_last  (rd_last),
    .tap_x     (delay_q),
    .tap_h     (coef_q),
    .done      (core_done),
    .result    (out_data)
  );

endmodule

// File: tb/tb_fir_mac_par.sv
// Directed bench: three lockstep instances (16-bit, 8-bit saturating,
// OUT_SHIFT=2 rounding) share every input; expectations are hand-computed.
`timescale 1ns/1ps
module tb_fir_mac_par;

  localparam int TAPS = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [15:0] coef_data = '0;

  logic               in_ready, out_valid, busy;
  logic signed [15:0] out_data;
  logic               in_ready8, out_valid8, busy8;
  logic signed [7:0]  out_data8;
  logic               in_ready_r, out_valid_r, busy_r;
  logic signed [15:0] out_data_r;

  int errors = 0;
  int checks = 0;
  logic signed [15:0] hset [TAPS];

  always #5 clk = ~clk;

  fir_mac_par #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .busy(busy));

  fir_mac_par #(.DATA_W(8), .COEF_W(16), .TAPS(TAPS), .OUT_SHIFT(0)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_valid(in_valid),
    .in_ready(in_ready8), .out_data(out_data8), .out_valid(out_valid8),
    .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .busy(busy8));

  fir_mac_par #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_SHIFT(2)) dut_r (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_r), .out_data(out_data_r), .out_valid(out_valid_r),
    .out_ready(out_ready), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .busy(busy_r));

  task automatic load_coefs();
    for (int i = 0; i < TAPS; i++) begin
      @(negedge clk);
      coef_we = 1'b1; coef_addr = 3'(i); coef_data = hset[i];
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Offers one sample and waits (bounded) for the result; latency is checked here.
  task automatic send_sample(input logic signed [15:0] x, input bit wr_coef,
                             input logic [2:0] wr_addr, input logic signed [15:0] wr_data);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    in_data = x; in_valid = 1'b1;
    coef_we = wr_coef; coef_addr = wr_addr; coef_data = wr_data;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
    checks++;
    if (lat !== 12) begin
      errors++;
      $display("[TB] FAIL latency: got %0d cycles, expected 12", lat);
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 1", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_data !== 16'sd0) begin errors++; $display("[TB] FAIL reset_out_data: got %0d expected 0", out_data); end
    rst = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); @(negedge clk); n++; end
    checks++; if (n !== TAPS) begin errors++; $display("[TB] FAIL clear_length: got %0d expected %0d", n, TAPS); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < TAPS; i++) hset[i] = (i == 0) ? 16'sd1 : 16'sd0;
    load_coefs();
    send_sample(16'sd5, 1'b0, 3'd0, 16'sd0);
    checks++; if (out_data !== 16'sd5) begin errors++; $display("[TB] FAIL impulse_out: got %0d expected 5", out_data); end
    checks++; if (out_data_r !== 16'sd1) begin errors++; $display("[TB] FAIL impulse_round: got %0d expected 1", out_data_r); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready: got %0b expected 0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL hold_busy: got %0b expected 1", busy); end
    ack();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ack_in_ready: got %0b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ack_out_valid: got %0b expected 0", out_valid); end
  endtask

  task automatic test_wrap();
    logic signed [15:0] expv;
    for (int i = 0; i < TAPS; i++) hset[i] = 16'(i + 1);
    load_coefs();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_sample((i == 0) ? 16'sd1 : 16'sd0, 1'b0, 3'd0, 16'sd0);
      expv = (i < 8) ? 16'(i + 1) : 16'sd0;
      checks++;
      if (out_data !== expv) begin
        errors++; $display("[TB] FAIL wrap_out[%0d]: got %0d expected %0d", i, out_data, expv);
      end
      ack();
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < TAPS; i++) hset[i] = 16'sd127;
    load_coefs();
    for (int i = 0; i < 8; i++) begin
      send_sample(16'sd127, 1'b0, 3'd0, 16'sd0);
      if (i == 0) begin
        checks++; if (out_data8 !== 8'sd127) begin errors++; $display("[TB] FAIL sat8_first: got %0d expected 127", out_data8); end
      end
      if (i < 7) ack();
    end
    checks++; if (out_data8 !== 8'sd127) begin errors++; $display("[TB] FAIL sat8_pos: got %0d expected 127", out_data8); end
    checks++; if (out_data !== 16'sh7FFF) begin errors++; $display("[TB] FAIL sat16_pos: got %0d expected 32767", out_data); end
    checks++; if (out_data_r !== 16'sd32258) begin errors++; $display("[TB] FAIL round_pos: got %0d expected 32258", out_data_r); end
    ack();
    for (int i = 0; i < 8; i++) begin
      send_sample(-16'sd128, 1'b0, 3'd0, 16'sd0);
      if (i < 7) ack();
    end
    checks++; if (out_data8 !== 8'sh80) begin errors++; $display("[TB] FAIL sat8_neg: got %0d expected -128", out_data8); end
    checks++; if (out_data !== 16'sh8000) begin errors++; $display("[TB] FAIL sat16_neg: got %0d expected -32768", out_data); end
    checks++; if (out_data_r !== -16'sd32512) begin errors++; $display("[TB] FAIL round_neg: got %0d expected -32512", out_data_r); end
    ack();
  endtask

  task automatic test_hold();
    bit stable;
    for (int i = 0; i < TAPS; i++) hset[i] = (i == 0) ? 16'sd1 : 16'sd0;
    load_coefs();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_out_ready: got busy=%0b in_ready=%0b out_valid=%0b expected 0 1 0", busy, in_ready, out_valid);
    end
    out_ready = 1'b0;
    send_sample(16'sd7, 1'b0, 3'd0, 16'sd0);
    stable = 1'b1;
    in_data = 16'sd100; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_data !== 16'sd7 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (stable !== 1'b1) begin errors++; $display("[TB] FAIL hold_stable: got %0b expected 1 (out_data=%0d)", stable, out_data); end
    ack();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_release: got in_ready=%0b out_valid=%0b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_mac();
    int n;
    bit saw_valid;
    for (int i = 0; i < TAPS; i++) hset[i] = 16'(i + 1);
    load_coefs();
    @(negedge clk);
    in_data = 16'sd9; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    saw_valid = out_valid;
    @(negedge clk);
    rst = 1'b0;
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd99;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
      if (out_valid) saw_valid = 1'b1;
    end
    coef_we = 1'b0;
    checks++; if (n !== TAPS) begin errors++; $display("[TB] FAIL midreset_clear: got %0d expected %0d", n, TAPS); end
    repeat (6) begin @(negedge clk); if (out_valid) saw_valid = 1'b1; end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %0b expected 0", saw_valid); end
    for (int i = 0; i < 3; i++) begin
      send_sample((i == 0) ? 16'sd1 : 16'sd0, 1'b0, 3'd0, 16'sd0);
      checks++;
      if (out_data !== 16'(i + 1)) begin
        errors++; $display("[TB] FAIL midreset_out[%0d]: got %0d expected %0d", i, out_data, i + 1);
      end
      ack();
    end
  endtask

  task automatic test_coef_guard();
    int n;
    int lat;
    for (int i = 0; i < TAPS; i++) hset[i] = (i == 0) ? 16'sd1 : 16'sd0;
    load_coefs();
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    in_data = 16'sd4; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd99;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); @(negedge clk); lat++; end
    repeat (3) begin @(posedge clk); @(negedge clk); end
    coef_we = 1'b0;
    checks++; if (lat !== 12) begin errors++; $display("[TB] FAIL guard_latency: got %0d expected 12", lat); end
    checks++; if (out_data !== 16'sd4) begin errors++; $display("[TB] FAIL guard_mac_out: got %0d expected 4", out_data); end
    ack();
    send_sample(16'sd3, 1'b0, 3'd0, 16'sd0);
    checks++; if (out_data !== 16'sd3) begin errors++; $display("[TB] FAIL guard_readback: got %0d expected 3", out_data); end
    ack();
    send_sample(16'sd3, 1'b1, 3'd0, 16'sd2);
    checks++; if (out_data !== 16'sd6) begin errors++; $display("[TB] FAIL same_cycle_coef: got %0d expected 6", out_data); end
    ack();
    send_sample(16'sd1, 1'b1, 3'd0, 16'sd6);
    checks++; if (out_data !== 16'sd6) begin errors++; $display("[TB] FAIL acc6_out: got %0d expected 6", out_data); end
    checks++; if (out_data_r !== 16'sd2) begin errors++; $display("[TB] FAIL round_acc6: got %0d expected 2", out_data_r); end
    ack();
    send_sample(-16'sd1, 1'b0, 3'd0, 16'sd0);
    checks++; if (out_data_r !== -16'sd1) begin errors++; $display("[TB] FAIL round_accm6: got %0d expected -1", out_data_r); end
    ack();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_impulse();
    test_wrap();
    test_saturation();
    test_hold();
    test_reset_mid_mac();
    test_coef_guard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
